// File: rtl/uart_pkg.sv
// uart_pkg: shared types, constants and helpers
// for the parametrised UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  typedef enum logic {
    PAR_EVEN,
    PAR_ODD
  } par_mode_e;

  localparam int MAX_DATA_W = 9;

  // Expected parity bit for a zero-extended data word.
  function automatic logic parity_bit(
    input logic [MAX_DATA_W-1:0] d,
    input par_mode_e mode
  );
    return (^d) ^ (mode == PAR_ODD);
  endfunction

  function automatic bit data_w_ok(input int w);
    return (w >= 5) && (w <= MAX_DATA_W);
  endfunction

  function automatic bit ovs_ok(input int o);
    return (o >= 8) && (o <= 32) && (o % 2 == 0);
  endfunction

  function automatic bit stop_ok(input int s);
    return (s == 1) || (s == 2);
  endfunction

  function automatic bit sync_ok(input int s);
    return s >= 2;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: rx synchroniser plus a 3-sample
// majority vote around the bit centre.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVS         = 16,
  parameter int SYNC_STAGES = 2,
  localparam int TW         = $clog2(OVS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          baud_tick,
  input  logic          rx,
  input  logic [TW-1:0] tick_cnt,
  output logic          rx_s,
  output logic          vote
);

  localparam logic [TW-1:0] TAP_A = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] TAP_B = TW'(OVS/2);

  logic [SYNC_STAGES-1:0] sync;
  logic                   samp_a;
  logic                   samp_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= '1;
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
      if (baud_tick && tick_cnt == TAP_A)
        samp_a <= rx_s;
      if (baud_tick && tick_cnt == TAP_B)
        samp_b <= rx_s;
    end
  end

  assign rx_s = sync[SYNC_STAGES-1];

  // Third vote is the live sample at tick OVS/2+1.
  assign vote = (samp_a & samp_b)
              | (samp_a & rx_s)
              | (samp_b & rx_s);

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver
// with majority vote, runtime parity and a valid/ready holding register.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int OVS         = 16,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              baud_tick,
  input  logic              rx,
  input  logic              parity_en,
  input  logic              parity_odd,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  input  logic              ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy,
  output logic              overrun
);

  if (!data_w_ok(DATA_W) || !ovs_ok(OVS) ||
      !stop_ok(STOP_BITS) || !sync_ok(SYNC_STAGES)) begin : g_bad_param
    $error("uart_rx_param: illegal parameter set");
  end

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVS/2 + 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  rx_state_e         state, state_n;
  logic [TW-1:0]     tick_cnt, tick_n;
  logic [BW-1:0]     bit_cnt, bit_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              par_pend, par_pend_n;
  logic              frm_pend, frm_pend_n;
  logic              par_en_l, par_en_n;
  par_mode_e         par_mode, par_mode_n;
  logic              armed, armed_n;
  logic              rx_s;
  logic              vote;
  logic              mid;
  logic              done;

  uart_rx_sampler #(
    .OVS         (OVS),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx        (rx),
    .tick_cnt  (tick_cnt),
    .rx_s      (rx_s),
    .vote      (vote)
  );

  assign mid  = (tick_cnt == TICK_MID);
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_pend <= 1'b0;
      frm_pend <= 1'b0;
      par_en_l <= 1'b0;
      par_mode <= PAR_EVEN;
      armed    <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      par_pend <= par_pend_n;
      frm_pend <= frm_pend_n;
      par_en_l <= par_en_n;
      par_mode <= par_mode_n;
      armed    <= armed_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_n     = tick_cnt;
    bit_n      = bit_cnt;
    shreg_n    = shreg;
    par_pend_n = par_pend;
    frm_pend_n = frm_pend;
    par_en_n   = par_en_l;
    par_mode_n = par_mode;
    armed_n    = armed;
    done       = 1'b0;
    if (!en) begin
      state_n    = IDLE;
      tick_n     = '0;
      bit_n      = '0;
      par_pend_n = 1'b0;
      frm_pend_n = 1'b0;
      armed_n    = 1'b0;
    end else if (baud_tick) begin
      if (state != IDLE)
        tick_n = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
      unique case (state)
        // A falling edge only counts once the line has been seen high.
        IDLE: begin
          if (rx_s) begin
            armed_n = 1'b1;
          end else if (armed) begin
            state_n    = START;
            tick_n     = '0;
            bit_n      = '0;
            armed_n    = 1'b0;
            par_pend_n = 1'b0;
            frm_pend_n = 1'b0;
          end
        end
        START: begin
          if (mid) begin
            if (vote) begin
              state_n = IDLE;
              tick_n  = '0;
            end else begin
              state_n    = DATA;
              par_en_n   = parity_en;
              par_mode_n = parity_odd ? PAR_ODD : PAR_EVEN;
            end
          end
        end
        DATA: begin
          if (mid) begin
            shreg_n = {vote, shreg[DATA_W-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_n   = '0;
              state_n = par_en_l ? PARITY : STOP;
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (mid) begin
            if (vote != parity_bit(MAX_DATA_W'(shreg), par_mode))
              par_pend_n = 1'b1;
            state_n = STOP;
          end
        end
        STOP: begin
          if (mid) begin
            if (!vote)
              frm_pend_n = 1'b1;
            if (bit_cnt == STOP_LAST) begin
              done    = 1'b1;
              state_n = IDLE;
              tick_n  = '0;
              bit_n   = '0;
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Holding register: a consumer handshake in the completion
  // cycle frees the slot for the new word.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!valid || ready) begin
          data_out   <= shreg;
          frame_err  <= frm_pend_n;
          parity_err <= par_pend_n;
          valid      <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed scoreboard bench for uart_rx_param
// with a 1-stop and a 2-stop instance on separate rx lines.
module tb_uart_rx_param;

  localparam int OVS = 16;
  // Start edge: 2 sync flops + detect tick + clear tick, then
  // majority at tick OVS/2+1 of the 10th bit (1 start, 8 data, 1 stop).
  localparam int LAT = 9*OVS + 2 + 2 + OVS/2 + 1;

  logic       clk = 1'b0;
  logic       rst, en, baud_tick, ready;
  logic       rx1, rx2, parity_en, parity_odd;
  logic [7:0] data1, data2;
  logic       valid1, fe1, pe1, busy1, ov1;
  logic       valid2, fe2, pe2, busy2, ov2;

  int nchecks = 0;
  int nerrors = 0;
  int cyc = 0;
  int f_start = 0;
  int load_cyc1 = 0;
  int ov_cnt1 = 0;
  int ov_cnt2 = 0;

  logic [9:0] q1[$];
  logic [9:0] q2[$];
  logic [9:0] e1, e2;
  logic       pv1 = 1'b0, pr1 = 1'b0;
  logic       pv2 = 1'b0, pr2 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_rx_param #(
    .DATA_W(8), .OVS(OVS), .STOP_BITS(1), .SYNC_STAGES(2)
  ) dut1 (
    .clk(clk), .rst(rst), .en(en), .baud_tick(baud_tick),
    .rx(rx1), .parity_en(parity_en), .parity_odd(parity_odd),
    .data_out(data1), .valid(valid1), .ready(ready),
    .frame_err(fe1), .parity_err(pe1), .busy(busy1),
    .overrun(ov1)
  );

  uart_rx_param #(
    .DATA_W(8), .OVS(OVS), .STOP_BITS(2), .SYNC_STAGES(2)
  ) dut2 (
    .clk(clk), .rst(rst), .en(en), .baud_tick(baud_tick),
    .rx(rx2), .parity_en(parity_en), .parity_odd(parity_odd),
    .data_out(data2), .valid(valid2), .ready(ready),
    .frame_err(fe2), .parity_err(pe2), .busy(busy2),
    .overrun(ov2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic drive(input int sel, input logic b);
    if (sel == 1) rx1 = b;
    else rx2 = b;
  endtask

  task automatic push(input int sel, input logic [7:0] d,
                      input logic fe, input logic pe);
    if (sel == 1) q1.push_back({fe, pe, d});
    else q2.push_back({fe, pe, d});
  endtask

  // Drives one frame; ready is pulsed for one clk at rdy_step.
  task automatic send(input int sel, input logic [7:0] d,
                      input logic par_on, input logic par_bit,
                      input logic [1:0] stops, input int nstop,
                      input int rdy_step);
    logic [15:0] bits;
    int n;
    bits = '1;
    n = 0;
    bits[n] = 1'b0;
    n++;
    for (int i = 0; i < 8; i++) begin
      bits[n] = d[i];
      n++;
    end
    if (par_on) begin
      bits[n] = par_bit;
      n++;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[n] = stops[i];
      n++;
    end
    f_start = cyc;
    for (int s = 0; s < n*OVS; s++) begin
      if (rdy_step >= 0 && s == rdy_step) ready = 1'b1;
      if (rdy_step >= 0 && s == rdy_step + 1) ready = 1'b0;
      drive(sel, bits[s/OVS]);
      step();
    end
    drive(sel, 1'b1);
  endtask

  always @(negedge clk) begin
    if (valid1 === 1'b1 && (pv1 === 1'b0 || pr1 === 1'b1)) begin
      chk("dut1 word expected", 32'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        chk("dut1 data_out", 32'(data1), 32'(e1[7:0]));
        chk("dut1 parity_err", 32'(pe1), 32'(e1[8]));
        chk("dut1 frame_err", 32'(fe1), 32'(e1[9]));
        load_cyc1 = cyc;
      end
    end
    if (ov1 === 1'b1) ov_cnt1++;
    pv1 = valid1;
    pr1 = ready;
  end

  always @(negedge clk) begin
    if (valid2 === 1'b1 && (pv2 === 1'b0 || pr2 === 1'b1)) begin
      chk("dut2 word expected", 32'(q2.size() > 0), 1);
      if (q2.size() > 0) begin
        e2 = q2.pop_front();
        chk("dut2 data_out", 32'(data2), 32'(e2[7:0]));
        chk("dut2 parity_err", 32'(pe2), 32'(e2[8]));
        chk("dut2 frame_err", 32'(fe2), 32'(e2[9]));
      end
    end
    if (ov2 === 1'b1) ov_cnt2++;
    pv2 = valid2;
    pr2 = ready;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    en = 1'b1;
    baud_tick = 1'b1;
    ready = 1'b1;
    rx1 = 1'b1;
    rx2 = 1'b1;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    idle(3);
    @(negedge clk);
    chk("rst data1", 32'(data1), 0);
    chk("rst valid1", 32'(valid1), 0);
    chk("rst fe1", 32'(fe1), 0);
    chk("rst pe1", 32'(pe1), 0);
    chk("rst busy1", 32'(busy1), 0);
    chk("rst ov1", 32'(ov1), 0);
    chk("rst data2", 32'(data2), 0);
    chk("rst valid2", 32'(valid2), 0);
    chk("rst busy2", 32'(busy2), 0);
    chk("rst ov2", 32'(ov2), 0);
    step();
    rst = 1'b0;
    idle(8);

    push(1, 8'hA5, 0, 0);
    send(1, 8'hA5, 0, 0, 2'b11, 1, -1);
    chk("a5 latency", 32'(load_cyc1 - f_start), LAT);
    idle(8);

    parity_en = 1'b1;
    push(1, 8'h07, 0, 1);
    send(1, 8'h07, 1, 0, 2'b11, 1, -1);
    push(1, 8'h07, 0, 0);
    send(1, 8'h07, 1, 1, 2'b11, 1, -1);
    parity_odd = 1'b1;
    push(1, 8'h07, 0, 0);
    send(1, 8'h07, 1, 0, 2'b11, 1, -1);
    parity_en = 1'b0;
    parity_odd = 1'b0;
    idle(8);

    rx1 = 1'b0;
    idle(4);
    rx1 = 1'b1;
    idle(2);
    chk("glitch busy", 32'(busy1), 1);
    idle(24);
    chk("glitch idle", 32'(busy1), 0);
    chk("glitch fe", 32'(fe1), 0);
    chk("glitch pe", 32'(pe1), 0);

    push(1, 8'h3C, 1, 0);
    send(1, 8'h3C, 0, 0, 2'b00, 1, -1);
    idle(32);

    ready = 1'b0;
    push(1, 8'h11, 0, 0);
    send(1, 8'h11, 0, 0, 2'b11, 1, -1);
    send(1, 8'h22, 0, 0, 2'b11, 1, -1);
    chk("ovr count", 32'(ov_cnt1), 1);
    chk("ovr hold data", 32'(data1), 32'h11);
    chk("ovr hold valid", 32'(valid1), 1);
    push(1, 8'h33, 0, 0);
    send(1, 8'h33, 0, 0, 2'b11, 1, LAT - 1);
    chk("ovr none", 32'(ov_cnt1), 1);
    chk("ovr new data", 32'(data1), 32'h33);
    ready = 1'b1;
    idle(8);

    rx1 = 1'b0;
    idle(16);
    rx1 = 1'b1;
    idle(16);
    rx1 = 1'b0;
    idle(16);
    rx1 = 1'b1;
    idle(16);
    chk("en busy before", 32'(busy1), 1);
    en = 1'b0;
    step();
    @(negedge clk);
    chk("en busy after", 32'(busy1), 0);
    step();
    en = 1'b1;
    idle(40);
    push(1, 8'hC3, 0, 0);
    send(1, 8'hC3, 0, 0, 2'b11, 1, -1);
    idle(8);

    ready = 1'b0;
    push(1, 8'h96, 1, 0);
    send(1, 8'h96, 0, 0, 2'b00, 1, -1);
    idle(32);
    rx1 = 1'b0;
    idle(40);
    chk("mid rst valid pre", 32'(valid1), 1);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("mid rst data", 32'(data1), 0);
    chk("mid rst valid", 32'(valid1), 0);
    chk("mid rst fe", 32'(fe1), 0);
    chk("mid rst pe", 32'(pe1), 0);
    chk("mid rst busy", 32'(busy1), 0);
    chk("mid rst ov", 32'(ov1), 0);
    step();
    rst = 1'b0;
    rx1 = 1'b1;
    ready = 1'b1;
    idle(40);

    push(2, 8'h5A, 1, 0);
    send(2, 8'h5A, 0, 0, 2'b01, 2, -1);
    idle(32);
    push(2, 8'h00, 1, 0);
    rx2 = 1'b0;
    idle(22*OVS);
    rx2 = 1'b1;
    idle(64);
    chk("break busy", 32'(busy2), 0);
    push(2, 8'h81, 0, 0);
    send(2, 8'h81, 0, 0, 2'b11, 2, -1);
    idle(32);

    chk("q1 drained", 32'(q1.size()), 0);
    chk("q2 drained", 32'(q2.size()), 0);
    chk("dut2 no overrun", 32'(ov_cnt2), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             nchecks, nerrors);
    $finish;
  end

endmodule
